cpu_io_bridge: RTL and testbench
================================

Name: cpu_io_bridge

Overview:
- Peripheral-side counterpart of the processor's 16-bit I/O port.
- Captures every value the CPU emits on its OUT path and queues it in a TX FIFO toward a host/testbench stream.
- Queues host-supplied words in an RX FIFO and presents the head word on the CPU's data input; the CPU consumes it with an IN acknowledge.
- Sits between the CPU core and the top-level/host side of the system.

Parameters:
WIDTH, 16, data word width (matches CPU port width)
DEPTH, 8, entries per FIFO; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset
cpu_data_out  input  WIDTH  value driven by CPU OUT instruction
cpu_out_stb  input  1  1-cycle pulse: cpu_data_out holds a new word to enqueue
cpu_data_in  output  WIDTH  head of RX FIFO to CPU; 16'h0000 when RX empty
cpu_in_avail  output  1  RX FIFO non-empty
cpu_in_ack  input  1  1-cycle pulse: CPU consumed cpu_data_in (pop RX)
host_tx_data  output  WIDTH  head of TX FIFO
host_tx_valid  output  1  TX FIFO non-empty
host_tx_ready  input  1  host accepts host_tx_data this cycle
host_rx_data  input  WIDTH  word from host
host_rx_valid  input  1  host_rx_data valid
host_rx_ready  output  1  RX FIFO can accept (not full)
flag_clr  input  1  clears sticky ovf/udf
ovf  output  1  sticky: TX push dropped (TX full)
udf  output  1  sticky: cpu_in_ack while RX empty

Behaviour:
- Reset (rst==0 at clk edge): both FIFO read/write pointers = 0, ovf = udf = 0. Consequently host_tx_valid = 0, cpu_in_avail = 0, cpu_data_in = 0, host_rx_ready = 1 from the first cycle after reset. Storage contents are not reset.
- Reset mid-operation: all queued words in both FIFOs are discarded, with no partial handshake completed.
- Pointers: log2(DEPTH)+1 bits, wrapping naturally.
  - empty = (wp == rp).
  - full = MSBs differ and the lower bits are equal.
  - count = wp - rp, modulo 2^(log2(DEPTH)+1).
- TX push: on cpu_out_stb && !tx_full, write cpu_data_out at wp and increment wp.
  - Exception: tx_full with a same-cycle TX pop. The push is accepted and count is unchanged.
  - If tx_full and no same-cycle pop, the word is dropped and ovf is set to 1.
- TX pop: a transfer occurs when host_tx_valid && host_tx_ready; rp increments.
  - host_tx_data/host_tx_valid are driven from registered state only; no combinational path from host_tx_ready.
- TX latency: a word pushed into an empty TX FIFO appears on host_tx_valid one cycle after the strobe edge. There is no write-through bypass.
- RX push: a transfer occurs when host_rx_valid && host_rx_ready.
  - host_rx_ready = !rx_full, computed from registered pointers only; a same-cycle CPU pop does not raise ready.
  - Host data is never dropped: the host must hold the word until ready.
- RX pop: cpu_in_ack with RX non-empty increments rp. The next word, or 0 if now empty, appears on cpu_data_in the following cycle.
  - cpu_in_ack with RX empty: no pointer change, udf set to 1.
- Simultaneous RX push and pop when non-empty and not full: both happen, count unchanged.
- cpu_data_in = mem_rx[rp] when non-empty, else 16'h0000. Mux driven from registered state.
- Flags: flag_clr clears ovf/udf in that cycle. A set event in the same cycle as flag_clr has priority and the flag stays 1.
- Pointer wrap: after DEPTH pushes and pops, pointers wrap to 0 with no loss or duplication.
- Data order: FIFO order is strictly preserved in both directions.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> host_tx_valid=0, cpu_in_avail=0, cpu_data_in=16'h0000, host_rx_ready=1, ovf=udf=0.
- TX fill/overflow: host_tx_ready=0, pulse cpu_out_stb 9 times with 16'h1000..16'h1008 -> 8 words held, ovf=1 after 9th. Then ready=1 -> host sees 16'h1000..16'h1007 in order, valid drops after 8th.
- TX full with simultaneous push/pop: TX full, host_tx_ready=1 and cpu_out_stb with 16'hBEEF same cycle -> ovf stays 0, count stays 8, 16'hBEEF emerges last.
- RX flow: host sends 16'hA5A5, 16'h5A5A -> cpu_in_avail=1 next cycle, cpu_data_in=16'hA5A5. After ack it shows 16'h5A5A; after 2nd ack it is 16'h0000 with avail=0. A 3rd ack sets udf=1.
- RX backpressure and wrap: host streams 20 words (0..19) with host_rx_valid held, CPU acks every 3rd cycle -> host_rx_ready deasserts at 8 queued, CPU receives 0..19 in order, no loss across pointer wrap.
- Flag clear priority and mid-op reset: flag_clr together with a new overflow -> ovf stays 1; flag_clr alone -> ovf=0. Assert rst with 5 words in each FIFO -> both empty next cycle, flags 0.

Source files
------------

// File: rtl/cpu_io_bridge.sv
// Peripheral side of the CPU's 16-bit I/O port: TX FIFO captures CPU OUT words
// for the host, RX FIFO queues host words for CPU IN.

module cpu_io_bridge_fifo #(
  parameter int WIDTH            = 16,
  parameter int DEPTH            = 8,
  parameter bit PUSH_ON_FULL_POP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop_ok;
  logic             push_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || (PUSH_ON_FULL_POP && pop_ok));

  // Head is a mux over registered pointers and storage only.
  assign head = empty ? '0 : mem[rp[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (rst && push_ok) mem[wp[AW-1:0]] <= push_data;
  end

endmodule

module cpu_io_bridge #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cpu_data_out,
  input  logic             cpu_out_stb,
  output logic [WIDTH-1:0] cpu_data_in,
  output logic             cpu_in_avail,
  input  logic             cpu_in_ack,
  output logic [WIDTH-1:0] host_tx_data,
  output logic             host_tx_valid,
  input  logic             host_tx_ready,
  input  logic [WIDTH-1:0] host_rx_data,
  input  logic             host_rx_valid,
  output logic             host_rx_ready,
  input  logic             flag_clr,
  output logic             ovf,
  output logic             udf
);

  logic tx_empty;
  logic tx_full;
  logic rx_empty;
  logic rx_full;
  logic ovf_set;
  logic udf_set;

  // A full TX FIFO still takes a strobe when the host drains a word that cycle.
  cpu_io_bridge_fifo #(
    .WIDTH            (WIDTH),
    .DEPTH            (DEPTH),
    .PUSH_ON_FULL_POP (1'b1)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cpu_out_stb),
    .push_data (cpu_data_out),
    .pop       (host_tx_ready),
    .head      (host_tx_data),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  // RX ready comes from registered fullness only, so the host never sees a
  // ready that depends on the CPU's same-cycle acknowledge.
  cpu_io_bridge_fifo #(
    .WIDTH            (WIDTH),
    .DEPTH            (DEPTH),
    .PUSH_ON_FULL_POP (1'b0)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (host_rx_valid),
    .push_data (host_rx_data),
    .pop       (cpu_in_ack),
    .head      (cpu_data_in),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  assign host_tx_valid = !tx_empty;
  assign cpu_in_avail  = !rx_empty;
  assign host_rx_ready = !rx_full;

  // A full TX FIFO is never empty, so a ready host always frees a slot.
  assign ovf_set = cpu_out_stb && tx_full && !host_tx_ready;
  assign udf_set = cpu_in_ack && rx_empty;

  // Set events win over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (ovf_set)       ovf <= 1'b1;
      else if (flag_clr) ovf <= 1'b0;
      if (udf_set)       udf <= 1'b1;
      else if (flag_clr) udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Directed and randomized check of cpu_io_bridge against a queue-based model
// of the two FIFOs and the sticky flags.

module tb_cpu_io_bridge;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] cpu_data_out;
  logic             cpu_out_stb;
  logic [WIDTH-1:0] cpu_data_in;
  logic             cpu_in_avail;
  logic             cpu_in_ack;
  logic [WIDTH-1:0] host_tx_data;
  logic             host_tx_valid;
  logic             host_tx_ready;
  logic [WIDTH-1:0] host_rx_data;
  logic             host_rx_valid;
  logic             host_rx_ready;
  logic             flag_clr;
  logic             ovf;
  logic             udf;

  cpu_io_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .cpu_data_out  (cpu_data_out),
    .cpu_out_stb   (cpu_out_stb),
    .cpu_data_in   (cpu_data_in),
    .cpu_in_avail  (cpu_in_avail),
    .cpu_in_ack    (cpu_in_ack),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .flag_clr      (flag_clr),
    .ovf           (ovf),
    .udf           (udf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: plain queues plus two flag bits.
  logic [WIDTH-1:0] tx_q [$];
  logic [WIDTH-1:0] rx_q [$];
  logic             ovf_m = 1'b0;
  logic             udf_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Applies one clock edge worth of spec rules to the model, using pre-edge inputs.
  task automatic model_update();
    bit tx_pop, ovf_ev, udf_ev;
    if (!rst) begin
      tx_q.delete();
      rx_q.delete();
      ovf_m = 1'b0;
      udf_m = 1'b0;
      return;
    end
    tx_pop = host_tx_ready && (tx_q.size() != 0);
    ovf_ev = 1'b0;
    if (cpu_out_stb && tx_q.size() == DEPTH && !tx_pop) ovf_ev = 1'b1;
    if (tx_pop) void'(tx_q.pop_front());
    if (cpu_out_stb && !ovf_ev) tx_q.push_back(cpu_data_out);

    udf_ev = cpu_in_ack && (rx_q.size() == 0);
    if (host_rx_valid && rx_q.size() < DEPTH) begin
      if (cpu_in_ack && rx_q.size() != 0) void'(rx_q.pop_front());
      rx_q.push_back(host_rx_data);
    end else if (cpu_in_ack && rx_q.size() != 0) begin
      void'(rx_q.pop_front());
    end

    if (ovf_ev) ovf_m = 1'b1; else if (flag_clr) ovf_m = 1'b0;
    if (udf_ev) udf_m = 1'b1; else if (flag_clr) udf_m = 1'b0;
  endtask

  task automatic check_all();
    check("tx_valid", host_tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) check("tx_data", host_tx_data, tx_q[0]);
    check("in_avail", cpu_in_avail, rx_q.size() != 0);
    check("in_data", cpu_data_in, (rx_q.size() != 0) ? rx_q[0] : 16'h0000);
    check("rx_ready", host_rx_ready, rx_q.size() < DEPTH);
    check("ovf", ovf, ovf_m);
    check("udf", udf, udf_m);
  endtask

  // One clock: model follows the edge, DUT sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    cpu_out_stb   = 1'b0;
    cpu_data_out  = '0;
    cpu_in_ack    = 1'b0;
    host_tx_ready = 1'b0;
    host_rx_valid = 1'b0;
    host_rx_data  = '0;
    flag_clr      = 1'b0;
  endtask

  task automatic tx_push(input logic [WIDTH-1:0] d);
    cpu_out_stb  = 1'b1;
    cpu_data_out = d;
    step();
    cpu_out_stb  = 1'b0;
  endtask

  logic [WIDTH-1:0] recv [$];
  int  sent;
  int  cyc;
  bit  saw_bp;
  bit  xfer;

  initial begin
    rst = 1'b0;
    idle_inputs();

    // Reset then idle.
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_tx_valid", host_tx_valid, 0);
    check("rst_in_avail", cpu_in_avail, 0);
    check("rst_in_data", cpu_data_in, 16'h0000);
    check("rst_rx_ready", host_rx_ready, 1);
    check("rst_ovf", ovf, 0);
    check("rst_udf", udf, 0);

    // TX fill and overflow.
    for (int i = 0; i < 9; i++) tx_push(16'h1000 + i[15:0]);
    check("ovf_after_9", ovf, 1);
    host_tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("tx_order", host_tx_data, 16'h1000 + k[15:0]);
      step();
    end
    check("tx_drained", host_tx_valid, 0);
    host_tx_ready = 1'b0;
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("ovf_cleared", ovf, 0);

    // TX full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) tx_push(16'h2000 + i[15:0]);
    host_tx_ready = 1'b1;
    tx_push(16'hBEEF);
    check("full_pushpop_ovf", ovf, 0);
    check("full_pushpop_ready_state", host_tx_valid, 1);
    for (int k = 0; k < 8; k++) begin
      check("tx_order2", host_tx_data, (k < 7) ? 16'h2001 + k[15:0] : 16'hBEEF);
      step();
    end
    check("tx_drained2", host_tx_valid, 0);
    host_tx_ready = 1'b0;

    // RX flow and underflow.
    host_rx_valid = 1'b1;
    host_rx_data  = 16'hA5A5;
    step();
    check("rx_avail", cpu_in_avail, 1);
    check("rx_head0", cpu_data_in, 16'hA5A5);
    host_rx_data  = 16'h5A5A;
    step();
    host_rx_valid = 1'b0;
    cpu_in_ack    = 1'b1;
    step();
    check("rx_head1", cpu_data_in, 16'h5A5A);
    step();
    check("rx_empty_data", cpu_data_in, 16'h0000);
    check("rx_empty_avail", cpu_in_avail, 0);
    step();
    cpu_in_ack = 1'b0;
    check("udf_set", udf, 1);
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
    check("udf_cleared", udf, 0);

    // RX backpressure and pointer wrap: 20 words, CPU acks every 3rd cycle.
    sent   = 0;
    cyc    = 0;
    saw_bp = 1'b0;
    while (recv.size() < 20 && cyc < 300) begin
      host_rx_valid = (sent < 20);
      host_rx_data  = sent[15:0];
      cpu_in_ack    = (cyc % 3 == 2) && cpu_in_avail;
      if (cpu_in_ack) recv.push_back(cpu_data_in);
      if (host_rx_valid && !host_rx_ready) saw_bp = 1'b1;
      xfer = host_rx_valid && host_rx_ready;
      step();
      if (xfer) sent++;
      cyc++;
    end
    idle_inputs();
    check("rx_stream_count", recv.size(), 20);
    check("rx_backpressure_seen", saw_bp, 1);
    for (int i = 0; i < recv.size(); i++) check("rx_stream_order", recv[i], i);

    // Flag clear priority, then mid-operation reset.
    for (int i = 0; i < 9; i++) tx_push(16'h3000 + i[15:0]);
    flag_clr = 1'b1;
    tx_push(16'h30FF);
    check("clr_vs_set_ovf", ovf, 1);
    step();
    flag_clr = 1'b0;
    check("clr_alone_ovf", ovf, 0);
    host_tx_ready = 1'b1;
    repeat (3) step();
    host_tx_ready = 1'b0;
    cpu_in_ack = 1'b1;
    step();
    cpu_in_ack = 1'b0;
    check("udf_before_rst", udf, 1);
    host_rx_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_rx_data = 16'h4000 + i[15:0];
      step();
    end
    host_rx_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("midrst_tx_valid", host_tx_valid, 0);
    check("midrst_in_avail", cpu_in_avail, 0);
    check("midrst_in_data", cpu_data_in, 16'h0000);
    check("midrst_rx_ready", host_rx_ready, 1);
    check("midrst_ovf", ovf, 0);
    check("midrst_udf", udf, 0);

    // Randomized traffic against the model, including occasional resets.
    for (int n = 0; n < 2000; n++) begin
      rst           = ($urandom_range(0, 199) != 0);
      cpu_out_stb   = ($urandom_range(0, 9) < 6);
      cpu_data_out  = WIDTH'($urandom);
      host_tx_ready = ($urandom_range(0, 9) < 5);
      host_rx_valid = ($urandom_range(0, 9) < 6);
      host_rx_data  = WIDTH'($urandom);
      cpu_in_ack    = ($urandom_range(0, 9) < 4);
      flag_clr      = ($urandom_range(0, 19) == 0);
      step();
    end
    rst = 1'b1;
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
